// File: rtl/msr_pkg.sv
// Shared definitions for the mode shift register: shift mode encodings,
// multi-cycle shift FSM states and shift direction constants.
package msr_pkg;

    // Shift mode encodings; 2'b11 is reserved and treated as logical
    localparam logic [1:0] MODE_LOG = 2'b00;
    localparam logic [1:0] MODE_ARI = 2'b01;
    localparam logic [1:0] MODE_ROT = 2'b10;

    // Shift directions
    localparam logic DIR_R = 1'b0;
    localparam logic DIR_L = 1'b1;

    // Multi-cycle shift engine states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/msr_shift_step.sv
// Combinational one-bit shifter used by both the single-step shift path and
// the multi-cycle shift engine of mode_shift_register.
module msr_shift_step
    import msr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             fill,
    output logic [WIDTH-1:0] next,
    output logic             shout
);

    // Select the fill bit by mode and report the bit that falls off the end
    always_comb begin
        next  = value;
        shout = 1'b0;
        if (dir == DIR_R) begin
            shout = value[0];
            case (mode)
                MODE_ARI: next = {value[WIDTH-1], value[WIDTH-1:1]};
                MODE_ROT: next = {value[0], value[WIDTH-1:1]};
                default:  next = {fill, value[WIDTH-1:1]};
            endcase
        end else begin
            shout = value[WIDTH-1];
            case (mode)
                MODE_ARI: next = {value[WIDTH-2:0], 1'b0};
                MODE_ROT: next = {value[WIDTH-2:0], value[WIDTH-1]};
                default:  next = {value[WIDTH-2:0], fill};
            endcase
        end
    end

endmodule

// File: rtl/mode_shift_register.sv
// Parametrised datapath working register: clear, load, increment, decrement,
// single-step shifts in logical/arithmetic/rotate modes, a carry/borrow flag
// and a multi-cycle shift-by-N engine with a busy/done handshake.
// Optional feature: define MSR_SATURATE_EN to make inc/dec saturate instead
// of wrapping (carry still reports the overflow/underflow attempt).
module mode_shift_register
    import msr_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              SHW     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cl,
    input  logic             ld,
    input  logic             inc,
    input  logic             dec,
    input  logic             sr,
    input  logic             ir,
    input  logic             sl,
    input  logic             il,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic             dir,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [SHW-1:0]   cnt;
    logic             lat_dir;
    logic [1:0]       lat_mode;
    logic             lat_fill;

    logic             step_dir;
    logic [1:0]       step_mode;
    logic             step_fill;
    logic [WIDTH-1:0] step_next;
    logic             step_out;

    logic [WIDTH:0]   inc_sum;
    logic [WIDTH:0]   dec_diff;

    assign zero     = (out == '0);
    assign inc_sum  = {1'b0, out} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_diff = {1'b0, out} - {{WIDTH{1'b0}}, 1'b1};

    // Feed the shared shifter from the latched settings while shifting, else from the live inputs
    always_comb begin
        if (state == SHIFT) begin
            step_dir  = lat_dir;
            step_mode = lat_mode;
            step_fill = lat_fill;
        end else begin
            step_dir  = sr ? DIR_R : DIR_L;
            step_mode = mode;
            step_fill = sr ? ir : il;
        end
    end

    msr_shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .value (out),
        .dir   (step_dir),
        .mode  (step_mode),
        .fill  (step_fill),
        .next  (step_next),
        .shout (step_out)
    );

    // Register update and shift engine FSM; busy and done are registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out      <= RST_VAL;
            carry    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            state    <= IDLE;
            cnt      <= '0;
            lat_dir  <= DIR_R;
            lat_mode <= MODE_LOG;
            lat_fill <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    if (cl) begin
                        out   <= '0;
                        carry <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        out   <= step_next;
                        carry <= step_out;
                        cnt   <= cnt - 1'b1;
                        if (cnt == SHW'(1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                    if (cl) begin
                        out   <= '0;
                        carry <= 1'b0;
                    end else if (start) begin
                        lat_dir  <= dir;
                        lat_mode <= mode;
                        lat_fill <= (dir == DIR_R) ? ir : il;
                        cnt      <= shamt;
                        if (shamt == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= SHIFT;
                        end
                    end else if (ld) begin
                        out   <= in;
                        carry <= 1'b0;
                    end else if (inc) begin
`ifdef MSR_SATURATE_EN
                        if (&out) begin
                            carry <= 1'b1;
                        end else begin
                            out   <= inc_sum[WIDTH-1:0];
                            carry <= inc_sum[WIDTH];
                        end
`else
                        out   <= inc_sum[WIDTH-1:0];
                        carry <= inc_sum[WIDTH];
`endif
                    end else if (dec) begin
`ifdef MSR_SATURATE_EN
                        if (zero) begin
                            carry <= 1'b1;
                        end else begin
                            out   <= dec_diff[WIDTH-1:0];
                            carry <= dec_diff[WIDTH];
                        end
`else
                        out   <= dec_diff[WIDTH-1:0];
                        carry <= dec_diff[WIDTH];
`endif
                    end else if (sr || sl) begin
                        out   <= step_next;
                        carry <= step_out;
                    end
                end
            endcase
        end
    end

endmodule
